// File: rtl/instr_mem_pkg.sv
// Shared constants and FSM encoding for the instruction memory
// sequencer: address/word widths, depth, states and the NOP word.
package instr_mem_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fsm_state_t;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

endpackage

// File: rtl/instr_port_mux.sv
// Single-port memory steering between loader writes and fetch reads.
// Ports: load_sel/addr/data, fetch_sel/addr -> mem_addr/we/wdata.
module instr_port_mux
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W  = instr_mem_pkg::ADDR_W,
  parameter int INSTR_W = instr_mem_pkg::INSTR_W
) (
  input  logic               load_sel,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               fetch_sel,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [INSTR_W-1:0] mem_wdata
);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (1'b1)
      load_sel: begin
        mem_addr  = load_addr;
        mem_we    = 1'b1;
        mem_wdata = load_data;
      end
      fetch_sel: mem_addr = fetch_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Loader/fetch sequencer owning the instruction memory port.
// Ports: load_*, run_start, stall in; mem_* port; if_* bundle; status.
module instr_fetch_ctrl #(
  parameter int ADDR_W  = instr_mem_pkg::ADDR_W,
  parameter int INSTR_W = instr_mem_pkg::INSTR_W,
  parameter int DEPTH   = instr_mem_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  input  logic               run_start,
  input  logic               stall,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               busy,
  output logic               done,
  output logic               load_err
);

  import instr_mem_pkg::*;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  fsm_state_t state_q, state_d;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   prog_len;

  logic start_load;
  logic start_run;
  logic empty_run;
  logic do_write;
  logic load_ovf;
  logic issue;
  logic last_issue;

  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    start_run  = 1'b0;
    empty_run  = 1'b0;
    do_write   = 1'b0;
    load_ovf   = 1'b0;
    issue      = 1'b0;
    last_issue = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          state_d    = LOAD;
          start_load = 1'b1;
        end else if (run_start) begin
          start_run = 1'b1;
          if (prog_len == '0) begin
            state_d   = DONE;
            empty_run = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      LOAD: begin
        if (load_valid) begin
          if (prog_len == LEN_MAX) begin
            load_ovf = 1'b1;
            state_d  = IDLE;
          end else begin
            do_write = 1'b1;
            if (load_last) state_d = IDLE;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if ({1'b0, pc} == prog_len - LEN_ONE) begin
            last_issue = 1'b1;
            state_d    = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc       <= '0;
      wr_ptr   <= '0;
      prog_len <= '0;
      if_valid <= 1'b0;
      if_instr <= INSTR_W'(NOP);
      if_pc    <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_load) begin
        wr_ptr   <= '0;
        prog_len <= '0;
        done     <= 1'b0;
        load_err <= 1'b0;
      end
      if (start_run) begin
        pc   <= '0;
        done <= empty_run;
        if (empty_run) load_err <= 1'b1;
      end
      if (do_write) begin
        wr_ptr   <= wr_ptr + ADDR_W'(1);
        prog_len <= prog_len + LEN_ONE;
      end
      if (load_ovf) load_err <= 1'b1;
      if (issue) begin
        if_instr <= mem_rdata;
        if_pc    <= pc;
        if_valid <= 1'b1;
        if (last_issue) done <= 1'b1;
        else pc <= pc + ADDR_W'(1);
      end
      // A stalled final instruction stays visible until stall drops.
      if (state_q != RUN && !stall) if_valid <= 1'b0;
    end
  end

  assign busy = (state_q == LOAD) || (state_q == RUN);

  instr_port_mux #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_port_mux (
    .load_sel  (do_write),
    .load_addr (wr_ptr),
    .load_data (load_data),
    .fetch_sel (state_q == RUN),
    .fetch_addr(pc),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequencer and owner of the 256x16 instruction memory port.
- Arbitrates the single memory port between a program loader (writes) and the pipeline fetch stage (reads).
- Generates the 8-bit program counter and registers the fetched instruction into the IF/ID boundary.
- Detects end-of-program from a loaded length register, not from memory contents.

Parameters:
- ADDR_W, 8, program counter / memory address width
- INSTR_W, 16, instruction word width
- DEPTH, 256, memory depth in words (must equal 2**ADDR_W)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load_start  input  1  pulse: begin program load at address 0
- load_valid  input  1  load_data valid this cycle
- load_data  input  INSTR_W  instruction word to write
- load_last  input  1  qualifies the final load_valid beat
- run_start  input  1  pulse: begin execution at PC 0
- stall  input  1  pipeline hazard stall; freeze fetch
- mem_addr  output  ADDR_W  memory address
- mem_we  output  1  memory write enable
- mem_wdata  output  INSTR_W  memory write data
- mem_rdata  input  INSTR_W  memory read data, combinational from mem_addr
- if_valid  output  1  if_instr/if_pc hold a valid fetch
- if_instr  output  INSTR_W  registered fetched instruction
- if_pc  output  ADDR_W  PC of if_instr
- busy  output  1  state is LOAD or RUN
- done  output  1  last instruction has been issued
- load_err  output  1  sticky: overflow or empty program

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE. Reset value is IDLE.
- Output reset values:
  - pc = 0, prog_len = 0 (ADDR_W+1 bits, range 0..256).
  - if_valid = 0, if_instr = 0, if_pc = 0.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - done = 0, load_err = 0.
- IDLE or DONE:
  - load_start -> LOAD; clears wr_ptr, prog_len, done and load_err.
  - Otherwise run_start -> RUN.
  - load_start and run_start together: load_start wins.
- LOAD:
  - Each load_valid beat: mem_we = 1, mem_addr = wr_ptr, mem_wdata = load_data, all combinational in the same cycle. Then wr_ptr++ and prog_len++.
  - load_valid with load_last -> IDLE after the write.
  - A beat arriving when prog_len == 256: write suppressed, load_err set, state -> IDLE.
  - run_start is ignored while in LOAD.
- RUN entry:
  - If prog_len == 0: set load_err, go to DONE, done = 1.
  - Otherwise pc = 0.
- RUN, fetch (mem_we = 0, mem_addr = pc):
  - Cycle with stall = 0: if_instr <= mem_rdata, if_pc <= pc, if_valid <= 1. Latency is one cycle from pc to if_instr.
  - If the issued pc == prog_len-1: go to DONE, done <= 1.
  - Else pc <= pc + 1.
  - pc never wraps: 255 is always the last pc because prog_len <= 256.
- RUN, stall = 1: pc, if_instr, if_pc and if_valid all hold.
- DONE:
  - The cycle after the final issue, if_valid <= 0 unless stall = 1. If stalled, the final instruction is held until stall drops, then if_valid clears.
  - done stays high until the next load_start or run_start.
  - run_start re-executes the loaded program from pc 0.
- Asynchronous reset mid-LOAD or mid-RUN returns all outputs to reset values. Memory contents are preserved, but prog_len = 0, so a reload is required.
- busy = (state == LOAD) || (state == RUN).

Decomposition:
- Shared package (instr_mem_pkg):
  - FSM state encoding (2-bit localparams IDLE/LOAD/RUN/DONE).
  - ADDR_W, INSTR_W and DEPTH constants.
  - NOP encoding 16'h0000, used as if_instr reset value.
- Optional sub-module: instr_port_mux, the combinational selection of mem_addr/mem_we/mem_wdata between the loader and fetch paths. The FSM, PC and IF register stay in the top.

Test Plan:
- Load 4 words {0x1111, 0x2222, 0x3333, 0x4444} with last on beat 4, then run_start:
  - mem_we pulses 4 times at addresses 0..3.
  - if_instr sequence 0x1111..0x4444 with if_pc 0..3 on consecutive cycles.
  - done rises on the cycle 0x4444 is captured; if_valid drops the next cycle.
- Same program, stall held high for 3 cycles while if_pc = 1:
  - if_instr stays 0x2222 and pc stays 2 for 3 cycles.
  - Sequence then resumes; total run is 7 cycles.
- Load 256 words, then a 257th beat:
  - 257th write suppressed, load_err = 1, state returns to IDLE.
  - A subsequent run fetches pc 0..255 and done rises at if_pc = 255 with no wrap.
- run_start with prog_len = 0 (immediately after reset): load_err = 1, done = 1, if_valid never asserts.
- Deassert rst_n mid-RUN at if_pc = 2:
  - All outputs are zero immediately, asynchronously.
  - A run_start after reset with no reload goes to DONE with load_err = 1.
- load_start and run_start asserted in the same IDLE cycle: LOAD is entered, no fetch occurs, busy = 1.
